// File: rtl/intensity_stream_source.sv
// -----------------------------------------------------------------------------
// intensity_stream_source
//
// Upstream producer for the silencer intensity interpolator. Each accepted
// update tick reads DEPTH+1 target intensities from a double-banked BRAM and
// emits them as one gap-free burst. DOUT_VALID marks word 0 only. Words
// 1..DEPTH follow on consecutive cycles.
//
// Timing, with the tick accepted at edge t:
//   - ADDR index k is presented after edge t+1+k.
//   - Word k is registered onto INTENSITY at edge t+2+READ_LATENCY+k.
//   - BUSY drops one cycle after word DEPTH has been output.
//
// Optional feature, enabled with the macro INTENSITY_SOURCE_FORCE_ZERO_EN:
//   - Adds input FORCE_ZERO, which is latched with an accepted tick.
//   - A latched 1 replaces every word of that burst with 0. ADDR sequencing
//     and timing do not change.
//
// Parameters:
//   DEPTH         index of the last element; burst length is DEPTH+1 words
//   READ_LATENCY  BRAM read latency in cycles (1..3), from ADDR to RDATA
//
// Ports:
//   CLK             system clock
//   RST_N           asynchronous active-low reset
//   UPDATE_TICK     one-cycle request to start a burst
//   BANK_SEL        BRAM bank to read, latched with an accepted tick
//   UPDATE_RATE_IN  silencer step limit, latched with an accepted tick
//   FORCE_ZERO      (optional) zero the whole burst, latched with the tick
//   ADDR            BRAM read address {bank, index}
//   RDATA           BRAM read data, READ_LATENCY cycles after ADDR
//   INTENSITY       streamed intensity word
//   DOUT_VALID      high only in the cycle carrying word 0
//   UPDATE_RATE     rate latched for the current burst
//   BUSY            high from tick acceptance through the last output word
//   OVERRUN_CNT     ticks dropped while busy; saturates at 255
// -----------------------------------------------------------------------------
module intensity_stream_source #(
  parameter  int DEPTH        = 249,
  parameter  int READ_LATENCY = 1,
  localparam int IW           = $clog2(DEPTH + 1),
  localparam int AW           = IW + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          UPDATE_TICK,
  input  logic          BANK_SEL,
  input  logic [15:0]   UPDATE_RATE_IN,
`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
  input  logic          FORCE_ZERO,
`endif
  output logic [AW-1:0] ADDR,
  input  logic [15:0]   RDATA,
  output logic [15:0]   INTENSITY,
  output logic          DOUT_VALID,
  output logic [15:0]   UPDATE_RATE,
  output logic          BUSY,
  output logic [7:0]    OVERRUN_CNT
);

  localparam logic [1:0]    IDLE     = 2'd0;
  localparam logic [1:0]    ISSUE    = 2'd1;
  localparam logic [1:0]    DRAIN    = 2'd2;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH);

  logic [1:0]              state_q,      state_d;
  logic [IW-1:0]           idx_q,        idx_d;
  logic                    bank_q,       bank_d;
  logic [15:0]             rate_q,       rate_d;
  logic                    force_q,      force_d;
  logic [AW-1:0]           addr_q,       addr_d;
  logic                    addr_vld_q,   addr_vld_d;
  logic                    addr_first_q, addr_first_d;
  logic [READ_LATENCY-1:0] vld_pipe_q,   vld_pipe_d;
  logic [READ_LATENCY-1:0] first_pipe_q, first_pipe_d;
  logic [15:0]             intensity_q,  intensity_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    busy_q,       busy_d;
  logic [7:0]              overrun_q,    overrun_d;

  // Flags for the word whose address is on ADDR (addr_vld_q, addr_first_q)
  // travel down a READ_LATENCY-deep shift register. The last stage lines up
  // with the matching RDATA, so no counter compare is needed.
  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_align
      if (gi == 0) begin : g_head
        assign vld_pipe_d[gi]   = addr_vld_q;
        assign first_pipe_d[gi] = addr_first_q;
      end else begin : g_tail
        assign vld_pipe_d[gi]   = vld_pipe_q[gi-1];
        assign first_pipe_d[gi] = first_pipe_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bank_d       = bank_q;
    rate_d       = rate_q;
    force_d      = force_q;
    addr_d       = addr_q;
    addr_vld_d   = 1'b0;
    addr_first_d = 1'b0;
    intensity_d  = intensity_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        if (UPDATE_TICK) begin
          state_d = ISSUE;
          idx_d   = '0;
          bank_d  = BANK_SEL;
          rate_d  = UPDATE_RATE_IN;
`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
          force_d = FORCE_ZERO;
`else
          force_d = 1'b0;
`endif
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        addr_d       = {bank_q, idx_q};
        addr_vld_d   = 1'b1;
        addr_first_d = (idx_q == '0);
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DRAIN: begin
        // Once every alignment flag has cleared, the last word was captured
        // at the previous edge. BUSY therefore falls one cycle after it.
        if (!addr_vld_q && (vld_pipe_q == '0)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A tick seen in any non-idle state is dropped. This includes the
    // final DRAIN cycle, where BUSY is about to fall.
    if (UPDATE_TICK && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    if (vld_pipe_q[READ_LATENCY-1]) begin
      intensity_d  = force_q ? 16'h0000 : RDATA;
      dout_valid_d = first_pipe_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bank_q       <= 1'b0;
      rate_q       <= '0;
      force_q      <= 1'b0;
      addr_q       <= '0;
      addr_vld_q   <= 1'b0;
      addr_first_q <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      intensity_q  <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bank_q       <= bank_d;
      rate_q       <= rate_d;
      force_q      <= force_d;
      addr_q       <= addr_d;
      addr_vld_q   <= addr_vld_d;
      addr_first_q <= addr_first_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      intensity_q  <= intensity_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ADDR        = addr_q;
  assign INTENSITY   = intensity_q;
  assign DOUT_VALID  = dout_valid_q;
  assign UPDATE_RATE = rate_q;
  assign BUSY        = busy_q;
  assign OVERRUN_CNT = overrun_q;

endmodule

// File: tb/tb_intensity_stream_source.sv
// -----------------------------------------------------------------------------
// tb_intensity_stream_source
//
// Drives two instances of intensity_stream_source, both with DEPTH=3:
//   - dut1 uses READ_LATENCY=1.
//   - dut3 uses READ_LATENCY=3.
// Each instance has its own BRAM model with the matching read latency:
//   - bank0 word i = 16'h0100*(i+1)
//   - bank1 word i = 16'hFFFF-i
// Cycle n means the cycle after the edge at which the tick was accepted plus
// n edges. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_intensity_stream_source;

  logic        clk;
  logic        rst_n;
  logic        tick1, tick3;
  logic        bank_sel;
  logic [15:0] rate_in;
  logic        force_zero;
  logic [2:0]  addr1, addr3;
  logic [15:0] rdata1, rdata3;
  logic [15:0] int1, int3;
  logic        dv1, dv3;
  logic [15:0] rate1, rate3;
  logic        busy1, busy3;
  logic [7:0]  ovr1, ovr3;
  logic [15:0] rd3_a, rd3_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int dv_count;

  localparam logic [2:0]  EXP_ADDR1 [0:8]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [15:0] EXP_INT1  [0:8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0200,
                                               16'h0300, 16'h0400, 16'h0400, 16'h0400};
  localparam logic [2:0]  EXP_ADDR3 [0:10] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                                               3'd7, 3'd7, 3'd7};
  localparam logic [15:0] EXP_INT3  [0:10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                               16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFC,
                                               16'hFFFC};
  localparam logic [15:0] EXP_B1    [0:3]  = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};

  intensity_stream_source #(.DEPTH(3), .READ_LATENCY(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .UPDATE_TICK(tick1), .BANK_SEL(bank_sel),
    .UPDATE_RATE_IN(rate_in),
`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
    .FORCE_ZERO(force_zero),
`endif
    .ADDR(addr1), .RDATA(rdata1), .INTENSITY(int1), .DOUT_VALID(dv1),
    .UPDATE_RATE(rate1), .BUSY(busy1), .OVERRUN_CNT(ovr1)
  );

  intensity_stream_source #(.DEPTH(3), .READ_LATENCY(3)) u_dut3 (
    .CLK(clk), .RST_N(rst_n), .UPDATE_TICK(tick3), .BANK_SEL(bank_sel),
    .UPDATE_RATE_IN(rate_in),
`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
    .FORCE_ZERO(force_zero),
`endif
    .ADDR(addr3), .RDATA(rdata3), .INTENSITY(int3), .DOUT_VALID(dv3),
    .UPDATE_RATE(rate3), .BUSY(busy3), .OVERRUN_CNT(ovr3)
  );

  function automatic logic [15:0] ram_val(input logic [2:0] a);
    logic [15:0] i;
    i = {14'd0, a[1:0]};
    return a[2] ? (16'hFFFF - i) : (16'h0100 * (i + 16'd1));
  endfunction

  // BRAM models
  always @(posedge clk) begin
    rdata1 <= ram_val(addr1);
    rd3_a  <= ram_val(addr3);
    rd3_b  <= rd3_a;
    rdata3 <= rd3_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after the accepting edge (cycle n=0).
  task automatic pulse1(input logic bank, input logic [15:0] rate);
    @(posedge clk); #1;
    bank_sel = bank; rate_in = rate; tick1 = 1'b1;
    @(posedge clk); #1;
    tick1 = 1'b0;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({addr1, int1, dv1, rate1, busy1, ovr1} !== 60'd0) begin
      tests_failed++;
      $display("FAIL reset_dut1 got addr=%0h int=%0h dv=%0b rate=%0h busy=%0b ovr=%0d want all 0",
               addr1, int1, dv1, rate1, busy1, ovr1);
    end
    tests_run++;
    if ({addr3, int3, dv3, rate3, busy3, ovr3} !== 60'd0) begin
      tests_failed++;
      $display("FAIL reset_dut3 got addr=%0h int=%0h dv=%0b rate=%0h busy=%0b ovr=%0d want all 0",
               addr3, int3, dv3, rate3, busy3, ovr3);
    end
  endtask

  task automatic test_burst_rl1;
    pulse1(1'b0, 16'd10);
    for (int n = 0; n <= 8; n++) begin
      tests_run++;
      if (addr1 !== EXP_ADDR1[n]) begin
        tests_failed++; $display("FAIL rl1_addr n=%0d got %0h want %0h", n, addr1, EXP_ADDR1[n]);
      end
      tests_run++;
      if (int1 !== EXP_INT1[n]) begin
        tests_failed++; $display("FAIL rl1_int n=%0d got %h want %h", n, int1, EXP_INT1[n]);
      end
      tests_run++;
      if (dv1 !== (n == 3)) begin
        tests_failed++; $display("FAIL rl1_dv n=%0d got %0b want %0b", n, dv1, (n == 3));
      end
      tests_run++;
      if (busy1 !== (n <= 6)) begin
        tests_failed++; $display("FAIL rl1_busy n=%0d got %0b want %0b", n, busy1, (n <= 6));
      end
      tests_run++;
      if (rate1 !== 16'd10) begin
        tests_failed++; $display("FAIL rl1_rate n=%0d got %0d want 10", n, rate1);
      end
      $display("[TB] rl1 n=%0d addr=%0h int=%h dv=%0b busy=%0b rate=%0d", n, addr1, int1, dv1, busy1, rate1);
      // Changes to the bank and the rate mid-burst must be ignored.
      if (n == 1) begin
        rate_in = 16'd99; bank_sel = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst_rl3_bank1;
    @(posedge clk); #1;
    bank_sel = 1'b1; rate_in = 16'd10; tick3 = 1'b1;
    @(posedge clk); #1;
    tick3 = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      tests_run++;
      if (addr3 !== EXP_ADDR3[n]) begin
        tests_failed++; $display("FAIL rl3_addr n=%0d got %0h want %0h", n, addr3, EXP_ADDR3[n]);
      end
      tests_run++;
      if (int3 !== EXP_INT3[n]) begin
        tests_failed++; $display("FAIL rl3_int n=%0d got %h want %h", n, int3, EXP_INT3[n]);
      end
      tests_run++;
      if (dv3 !== (n == 5)) begin
        tests_failed++; $display("FAIL rl3_dv n=%0d got %0b want %0b", n, dv3, (n == 5));
      end
      tests_run++;
      if (busy3 !== (n <= 8)) begin
        tests_failed++; $display("FAIL rl3_busy n=%0d got %0b want %0b", n, busy3, (n <= 8));
      end
      tests_run++;
      if (rate3 !== 16'd10) begin
        tests_failed++; $display("FAIL rl3_rate n=%0d got %0d want 10", n, rate3);
      end
      $display("[TB] rl3 n=%0d addr=%0h int=%h dv=%0b busy=%0b", n, addr3, int3, dv3, busy3);
      if (n == 2) begin
        rate_in = 16'd99; bank_sel = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overrun;
    pulse1(1'b0, 16'd10);
    dv_count = 0;
    for (int n = 0; n <= 7; n++) begin
      if (dv1) dv_count++;
      tests_run++;
      if (ovr1 !== ((n < 3) ? 8'd0 : ((n < 7) ? 8'd1 : 8'd2))) begin
        tests_failed++; $display("FAIL ovr_cnt n=%0d got %0d", n, ovr1);
      end
      tests_run++;
      if (busy1 !== (n <= 6)) begin
        tests_failed++; $display("FAIL ovr_busy n=%0d got %0b want %0b", n, busy1, (n <= 6));
      end
      if (n == 6) begin
        tests_run++;
        if (int1 !== 16'h0400) begin
          tests_failed++; $display("FAIL ovr_last_word got %h want 0400", int1);
        end
      end
      $display("[TB] ovr n=%0d ovr=%0d busy=%0b int=%h", n, ovr1, busy1, int1);
      // Ticks sampled at edges t+3 and t+7 are dropped; the one at t+8 is accepted.
      tick1 = (n == 2) || (n == 6) || (n == 7);
      @(posedge clk); #1;
    end
    tick1 = 1'b0;
    tests_run++;
    if (dv_count !== 1) begin
      tests_failed++; $display("FAIL ovr_dv_count got %0d want 1", dv_count);
    end
    tests_run++;
    if ({busy1, ovr1} !== {1'b1, 8'd2}) begin
      tests_failed++; $display("FAIL ovr_reaccept got busy=%0b ovr=%0d want busy=1 ovr=2", busy1, ovr1);
    end
    repeat (12) @(posedge clk);
    #1;
    tick1 = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    tick1 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if ({busy1, ovr1} !== {1'b0, 8'd255}) begin
      tests_failed++; $display("FAIL ovr_saturate got busy=%0b ovr=%0d want busy=0 ovr=255", busy1, ovr1);
    end
    $display("[TB] ovr saturate ovr=%0d busy=%0b", ovr1, busy1);
  endtask

  task automatic test_reset_mid_burst;
    pulse1(1'b0, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if ({int1, dv1} !== {16'h0200, 1'b0}) begin
      tests_failed++; $display("FAIL rst_pre_word1 got int=%h dv=%0b want 0200/0", int1, dv1);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({addr1, int1, dv1, rate1, busy1, ovr1} !== 60'd0) begin
      tests_failed++;
      $display("FAIL rst_mid got addr=%0h int=%0h dv=%0b rate=%0h busy=%0b ovr=%0d want all 0",
               addr1, int1, dv1, rate1, busy1, ovr1);
    end
    $display("[TB] rst_mid addr=%0h int=%h busy=%0b ovr=%0d", addr1, int1, busy1, ovr1);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({dv1, busy1, int1} !== 18'd0) begin
        tests_failed++;
        $display("FAIL rst_quiet n=%0d got dv=%0b busy=%0b int=%h want 0", n, dv1, busy1, int1);
      end
    end
    pulse1(1'b1, 16'd7);
    for (int n = 0; n <= 7; n++) begin
      if (n >= 1 && n <= 4) begin
        tests_run++;
        if (addr1 !== 3'(4 + n - 1)) begin
          tests_failed++; $display("FAIL rst_next_addr n=%0d got %0h want %0h", n, addr1, 3'(4 + n - 1));
        end
      end
      if (n >= 3 && n <= 6) begin
        tests_run++;
        if (int1 !== EXP_B1[n-3]) begin
          tests_failed++; $display("FAIL rst_next_int n=%0d got %h want %h", n, int1, EXP_B1[n-3]);
        end
      end
      tests_run++;
      if ({dv1, busy1, rate1} !== {(n == 3), (n <= 6), 16'd7}) begin
        tests_failed++;
        $display("FAIL rst_next_ctl n=%0d got dv=%0b busy=%0b rate=%0d", n, dv1, busy1, rate1);
      end
      $display("[TB] rst_next n=%0d addr=%0h int=%h dv=%0b busy=%0b", n, addr1, int1, dv1, busy1);
      @(posedge clk); #1;
    end
  endtask

`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
  task automatic test_force_zero;
    for (int b = 0; b < 2; b++) begin
      force_zero = (b == 0);
      pulse1(1'b0, 16'd5);
      force_zero = (b != 0);
      for (int n = 0; n <= 8; n++) begin
        if (n >= 1) begin
          tests_run++;
          if (addr1 !== EXP_ADDR1[n]) begin
            tests_failed++; $display("FAIL fz_addr b=%0d n=%0d got %0h want %0h", b, n, addr1, EXP_ADDR1[n]);
          end
        end
        if (n >= 3) begin
          tests_run++;
          if (int1 !== ((b == 0) ? 16'h0000 : EXP_INT1[n])) begin
            tests_failed++; $display("FAIL fz_int b=%0d n=%0d got %h", b, n, int1);
          end
        end
        tests_run++;
        if ({dv1, busy1} !== {(n == 3), (n <= 6)}) begin
          tests_failed++; $display("FAIL fz_ctl b=%0d n=%0d got dv=%0b busy=%0b", b, n, dv1, busy1);
        end
        $display("[TB] fz b=%0d n=%0d addr=%0h int=%h dv=%0b", b, n, addr1, int1, dv1);
        @(posedge clk); #1;
      end
    end
    force_zero = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; tick1 = 1'b0; tick3 = 1'b0; bank_sel = 1'b0;
    rate_in = 16'd0; force_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    test_burst_rl1;
    test_burst_rl3_bank1;
    test_overrun;
    test_reset_mid_burst;
`ifdef INTENSITY_SOURCE_FORCE_ZERO_EN
    test_force_zero;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
